// File: rtl/acq_sequencer.sv
// acq_sequencer: shot-level controller for the range-gated input buffer.
// Optional: define TRIG_SYNC_EN to run trig_in through a 2-flop synchronizer.
module acq_sequencer #(
  parameter int CNT_W   = 16,
  parameter int DLY_W   = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_pulses,
  input  logic [DLY_W-1:0] trig_delay,
  input  logic             trig_in,
  input  logic             buf_valid,
  output logic             start_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulse_idx,
  output logic [CNT_W-1:0] missed_cnt,
  output logic             timeout_err
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TRIG,
    S_DELAY,
    S_FIRE,
    S_WAIT_DATA,
    S_DRAIN
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [DLY_W-1:0] cnt_q, cnt_d;
  logic [TO_W-1:0]  tcnt_q, tcnt_d;
  logic [CNT_W-1:0] pidx_q, pidx_d;
  logic [CNT_W-1:0] miss_q, miss_d;
  logic [CNT_W-1:0] pidx_inc;
  logic             err_q, err_d;
  logic             start_q, start_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             trig_d_q;
  logic             trig_s;
  logic             trig_edge;
  logic             miss_ev;

`ifdef TRIG_SYNC_EN
  logic sync1_q, sync2_q;

  // two-flop synchronizer so trig_in may come from another clock domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= trig_in;
      sync2_q <= sync1_q;
    end
  end

  assign trig_s = sync2_q;
`else
  assign trig_s = trig_in;
`endif

  assign trig_edge = trig_s & ~trig_d_q;

  // edges that land while a shot is in flight are dropped and counted
  assign miss_ev = trig_edge &&
                   (state_q == S_DELAY     ||
                    state_q == S_FIRE      ||
                    state_q == S_WAIT_DATA ||
                    state_q == S_DRAIN);

  // next-state and output decode; abort overrides every transition
  always_comb begin
    state_d  = state_q;
    num_d    = num_q;
    dly_d    = dly_q;
    cnt_d    = cnt_q;
    tcnt_d   = tcnt_q;
    pidx_d   = pidx_q;
    miss_d   = miss_q;
    err_d    = err_q;
    start_d  = 1'b0;
    done_d   = 1'b0;
    pidx_inc = pidx_q + CNT_W'(1);

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (arm) begin
            if (num_pulses != '0) begin
              num_d   = num_pulses;
              dly_d   = trig_delay;
              pidx_d  = '0;
              miss_d  = '0;
              err_d   = 1'b0;
              state_d = S_WAIT_TRIG;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        S_WAIT_TRIG: begin
          if (trig_edge) begin
            if (dly_q == '0) begin
              start_d = 1'b1;
              state_d = S_FIRE;
            end else begin
              cnt_d   = dly_q;
              state_d = S_DELAY;
            end
          end
        end
        S_DELAY: begin
          // DELAY spans exactly trig_delay cycles
          if (cnt_q == DLY_W'(1)) begin
            start_d = 1'b1;
            state_d = S_FIRE;
          end else begin
            cnt_d = cnt_q - DLY_W'(1);
          end
        end
        S_FIRE: begin
          // counter holds cycles elapsed since start_out
          tcnt_d  = TO_W'(1);
          state_d = S_WAIT_DATA;
        end
        S_WAIT_DATA: begin
          if (buf_valid) begin
            state_d = S_DRAIN;
          end else if (tcnt_q >= TO_W'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            tcnt_d = tcnt_q + TO_W'(1);
          end
        end
        S_DRAIN: begin
          if (!buf_valid) begin
            pidx_d = pidx_inc;
            if (pidx_inc == num_q) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_WAIT_TRIG;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (miss_ev && miss_q != '1) begin
        miss_d = miss_q + CNT_W'(1);
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  // state, latched config, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      num_q    <= '0;
      dly_q    <= '0;
      cnt_q    <= '0;
      tcnt_q   <= '0;
      pidx_q   <= '0;
      miss_q   <= '0;
      err_q    <= 1'b0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      trig_d_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      num_q    <= num_d;
      dly_q    <= dly_d;
      cnt_q    <= cnt_d;
      tcnt_q   <= tcnt_d;
      pidx_q   <= pidx_d;
      miss_q   <= miss_d;
      err_q    <= err_d;
      start_q  <= start_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      trig_d_q <= trig_s;
    end
  end

  assign start_out   = start_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pulse_idx   = pidx_q;
  assign missed_cnt  = miss_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_acq_sequencer.sv
// tb_acq_sequencer: directed table, random runs against a shot-timeline
// model, and hand-written abort/timeout/reset sequences.
module tb_acq_sequencer;

`ifdef TRIG_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        arm;
  logic        abort;
  logic [15:0] num_pulses;
  logic [15:0] trig_delay;
  logic        trig_in;
  logic        buf_valid;
  logic        start_out;
  logic        busy;
  logic        done;
  logic [15:0] pulse_idx;
  logic [15:0] missed_cnt;
  logic        timeout_err;

  int cyc = 0;
  int checks = 0;
  int passes = 0;

  acq_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .arm         (arm),
    .abort       (abort),
    .num_pulses  (num_pulses),
    .trig_delay  (trig_delay),
    .trig_in     (trig_in),
    .buf_valid   (buf_valid),
    .start_out   (start_out),
    .busy        (busy),
    .done        (done),
    .pulse_idx   (pulse_idx),
    .missed_cnt  (missed_cnt),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n, d, p, w, v, l;
    int exp_starts, exp_missed;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_start"}, int'(start_out), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_pidx"}, int'(pulse_idx), 0);
    chk({tag, "_miss"}, int'(missed_cnt), 0);
    chk({tag, "_err"}, int'(timeout_err), 0);
  endtask

  // Runs one armed sequence. Triggers rise every p cycles (width w); the
  // buffer raises valid v cycles after each start for l cycles. Expected
  // start/done cycles and missed count come from the shot timeline.
  task automatic run_seq(input int n, input int d, input int p,
                         input int w, input int v, input int l,
                         input string tag,
                         output int o_starts, output int o_missed);
    int a, t0, e, fin, ready, acc, ms, done_cyc, end_cyc, vs;
    int exp_s[$];
    int got_s[$];
    int got_d[$];
    a = cyc + 2;
    t0 = a + 1 + int'($urandom_range(0, 10));
    acc = 0;
    ms = 0;
    ready = a + 1;
    done_cyc = -1;
    for (int k = 0; k < 5000; k++) begin
      e = t0 + k * p + SL;
      if (acc == n && e >= ready) break;
      if (acc < n && e >= ready) begin
        exp_s.push_back(e + d + 1);
        fin = e + d + 1 + v + l;
        ready = fin + 1;
        acc++;
        if (acc == n) done_cyc = fin + 1;
      end else begin
        ms++;
      end
    end
    end_cyc = done_cyc + 6;
    vs = -1000000;
    while (cyc < end_cyc) begin
      if (start_out) begin
        got_s.push_back(cyc);
        vs = cyc;
      end
      if (done) got_d.push_back(cyc);
      arm = (cyc == a);
      num_pulses = (cyc == a) ? 16'(n) : 16'($urandom);
      trig_delay = (cyc == a) ? 16'(d) : 16'($urandom);
      trig_in = (cyc >= t0) && (((cyc - t0) % p) < w);
      buf_valid = (cyc >= vs + v) && (cyc < vs + v + l);
      tick();
    end
    arm = 1'b0;
    trig_in = 1'b0;
    buf_valid = 1'b0;
    chk({tag, "_nstarts"}, got_s.size(), exp_s.size());
    foreach (exp_s[i]) begin
      chk($sformatf("%s_start%0d_cyc", tag, i),
          (i < got_s.size()) ? got_s[i] : -1, exp_s[i]);
    end
    chk({tag, "_ndone"}, got_d.size(), 1);
    chk({tag, "_done_cyc"}, (got_d.size() > 0) ? got_d[0] : -1, done_cyc);
    chk({tag, "_pidx"}, int'(pulse_idx), n);
    chk({tag, "_missed"}, int'(missed_cnt), ms);
    chk({tag, "_busy_end"}, int'(busy), 0);
    chk({tag, "_err_end"}, int'(timeout_err), 0);
    o_starts = got_s.size();
    o_missed = int'(missed_cnt);
    repeat (4) tick();
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[5];
    int gs, gm, s, r, f_start, f_done, f_busy;

    vecs[0] = '{3, 5, 400, 3, 10, 100, 3, 0};
    vecs[1] = '{1, 0, 60, 2, 4, 8, 1, 0};
    vecs[2] = '{2, 0, 50, 3, 10, 100, 2, 4};
    vecs[3] = '{2, 3, 20, 1, 5, 30, 2, 2};
    vecs[4] = '{2, 3, 20, 1, 5, 31, 2, 4};

    rst = 1'b1;
    arm = 1'b0;
    abort = 1'b0;
    num_pulses = '0;
    trig_delay = '0;
    trig_in = 1'b0;
    buf_valid = 1'b0;
    repeat (3) tick();
    chk_idle_outs("rst_held");
    rst = 1'b0;
    repeat (2) tick();
    chk_idle_outs("rst_rel");

    // directed table
    for (int i = 0; i < 5; i++) begin
      run_seq(vecs[i].n, vecs[i].d, vecs[i].p, vecs[i].w,
              vecs[i].v, vecs[i].l, $sformatf("vec%0d", i), gs, gm);
      chk($sformatf("vec%0d_hand_starts", i), gs, vecs[i].exp_starts);
      chk($sformatf("vec%0d_hand_missed", i), gm, vecs[i].exp_missed);
    end

    // random sequences
    for (int i = 0; i < 10; i++) begin
      int p;
      p = int'($urandom_range(4, 80));
      run_seq(int'($urandom_range(1, 3)), int'($urandom_range(0, 15)), p,
              int'($urandom_range(1, 3)), int'($urandom_range(1, 12)),
              int'($urandom_range(1, 40)), $sformatf("rnd%0d", i), gs, gm);
    end

    // arm with zero shots
    num_pulses = 16'd0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("zero_done", int'(done), 1);
    chk("zero_busy", int'(busy), 0);
    chk("zero_start", int'(start_out), 0);
    tick();
    chk("zero_done_once", int'(done), 0);
    f_start = 0;
    f_busy = 0;
    repeat (5) begin
      tick();
      f_start |= int'(start_out);
      f_busy |= int'(busy);
    end
    chk("zero_no_start", f_start, 0);
    chk("zero_no_busy", f_busy, 0);

    // buffer never answers
    num_pulses = 16'd1;
    trig_delay = 16'd2;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    trig_in = 1'b1;
    tick();
    trig_in = 1'b0;
    s = -1;
    for (int i = 0; i < 40 && s < 0; i++) begin
      if (start_out) s = cyc;
      else tick();
    end
    chk("to_start_seen", int'(s >= 0), 1);
    if (s >= 0) begin
      f_done = 0;
      while (cyc < s + 4095) begin
        tick();
        f_done |= int'(done);
      end
      chk("to_err_early", int'(timeout_err), 0);
      chk("to_busy_early", int'(busy), 1);
      tick();
      f_done |= int'(done);
      chk("to_err_set", int'(timeout_err), 1);
      chk("to_busy_clr", int'(busy), 0);
      chk("to_no_done", f_done, 0);
    end
    num_pulses = 16'd1;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("to_rearm_clr", int'(timeout_err), 0);
    chk("to_rearm_busy", int'(busy), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("to_abort_idle", int'(busy), 0);

    // abort during DELAY; an edge in the abort cycle is not counted
    num_pulses = 16'd1;
    trig_delay = 16'd10;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int i = 0; i <= 3 + SL; i++) begin
      trig_in = (i == 0) || (i == 3);
      abort = (i == 3 + SL);
      tick();
    end
    trig_in = 1'b0;
    abort = 1'b0;
    chk("abd_busy", int'(busy), 0);
    f_start = 0;
    f_done = 0;
    repeat (20) begin
      f_start |= int'(start_out);
      f_done |= int'(done);
      tick();
    end
    chk("abd_no_start", f_start, 0);
    chk("abd_no_done", f_done, 0);
    chk("abd_missed", int'(missed_cnt), 0);

    // abort during DRAIN
    num_pulses = 16'd2;
    trig_delay = 16'd0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    f_start = 0;
    f_done = 0;
    for (int i = 0; i <= SL + 15; i++) begin
      if (i == SL + 1) chk("abr_start", int'(start_out), 1);
      else f_start |= int'(start_out);
      f_done |= int'(done);
      if (i == SL + 7) chk("abr_busy", int'(busy), 0);
      trig_in = (i == 0);
      buf_valid = (i >= SL + 3) && (i <= SL + 12);
      abort = (i == SL + 6);
      tick();
    end
    trig_in = 1'b0;
    buf_valid = 1'b0;
    abort = 1'b0;
    chk("abr_no_extra_start", f_start, 0);
    chk("abr_no_done", f_done, 0);
    chk("abr_pidx", int'(pulse_idx), 0);

    // async reset in WAIT_DATA with a missed trigger recorded
    num_pulses = 16'd1;
    trig_delay = 16'd0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int i = 0; i <= SL + 8; i++) begin
      trig_in = (i == 0) || (i == 4);
      tick();
    end
    trig_in = 1'b0;
    chk("ar_pre_busy", int'(busy), 1);
    chk("ar_pre_missed", int'(missed_cnt), 1);
    #2;
    rst = 1'b1;
    #1;
    chk_idle_outs("ar_async");
    tick();
    rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
